// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC generator bus; master drives stall/redirect/exception controls, slave returns pc, pc_misaligned, redir_pending
interface pc_gen_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_target;
  logic             req;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic             pc_misaligned;
  logic             redir_pending;
  modport master (
    output stall, redir_valid, redir_target, req, eret, epc,
    input  pc, pc_misaligned, redir_pending
  );
  modport slave (
    input  stall, redir_valid, redir_target, req, eret, epc,
    output pc, pc_misaligned, redir_pending
  );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: IF-stage PC generator (ports clk, reset, bus: stall/redir/req/eret/epc in, pc/pc_misaligned/redir_pending out) with exception, ERET and stall-buffered redirect
module pc_gen_unit #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VEC   = 32'h3000,
  parameter logic [31:0] HANDLER_VEC = 32'h4180,
  parameter int          STEP        = 4,
  parameter int          ERET_OFFSET = 4
) (
  input logic        clk,
  input logic        reset,
  pc_gen_if.slave    bus
);
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] HV = WIDTH'(HANDLER_VEC);
  localparam logic [WIDTH-1:0] ST = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] EO = WIDTH'(ERET_OFFSET);
  state_t           state, state_n;
  logic [WIDTH-1:0] pc_q, pc_n, pend_q, pend_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= RV;
      pend_q <= '0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      pend_q <= pend_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    pend_n  = pend_q;
    if (bus.req) begin
      pc_n    = HV;
      state_n = IDLE;
    end else if (bus.eret) begin
      pc_n    = bus.epc + EO;
      state_n = IDLE;
    end else if (bus.stall) begin
      if (bus.redir_valid) begin
        pend_n  = bus.redir_target;
        state_n = PEND;
      end
    end else if (bus.redir_valid) begin
      pc_n    = bus.redir_target;
      state_n = IDLE;
    end else if (state == PEND) begin
      pc_n    = pend_q;
      state_n = IDLE;
    end else begin
      pc_n    = pc_q + ST;
    end
  end
  assign bus.pc            = pc_q;
  assign bus.pc_misaligned = |pc_q[1:0];
  assign bus.redir_pending = state == PEND;
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed self-checking bench for pc_gen_unit
module tb_pc_gen_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  pc_gen_if #(.WIDTH(32)) bus ();
  pc_gen_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic rv, input logic [31:0] rt, input logic rq, input logic er, input logic [31:0] ep);
    bus.stall        = s;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.req          = rq;
    bus.eret         = er;
    bus.epc          = ep;
  endtask
  task automatic chk(input string tag, input logic [31:0] epc_v, input logic ep);
    check({tag, "_pc"}, bus.pc, epc_v);
    check({tag, "_pend"}, 32'(bus.redir_pending), 32'(ep));
  endtask
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("rst1", 32'h3000, 0);
    check("rst1_mis", 32'(bus.pc_misaligned), 0);
    step(); chk("rst2", 32'h3000, 0);
    reset = 1'b0;
    step(); chk("seq1", 32'h3004, 0);
    step(); chk("seq2", 32'h3008, 0);
    step(); chk("seq3", 32'h300c, 0);
    step(); chk("seq4", 32'h3010, 0);
    drive(1, 1, 32'h3100, 0, 0, 0);
    step(); chk("stl_redir", 32'h3010, 1);
    drive(1, 0, 0, 0, 0, 0);
    step(); chk("stl_hold1", 32'h3010, 1);
    step(); chk("stl_hold2", 32'h3010, 1);
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("pend_load", 32'h3100, 0);
    step(); chk("pend_next", 32'h3104, 0);
    drive(1, 1, 32'h3300, 0, 0, 0);
    step(); chk("pend2", 32'h3104, 1);
    drive(1, 1, 32'h3380, 0, 0, 0);
    step(); chk("pend_over", 32'h3104, 1);
    drive(0, 1, 32'h3200, 0, 0, 0);
    step(); chk("live_wins", 32'h3200, 0);
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("live_drop", 32'h3204, 0);
    drive(1, 1, 32'h3400, 0, 0, 0);
    step(); chk("pend3", 32'h3204, 1);
    drive(1, 0, 0, 1, 0, 0);
    step(); chk("req_stall", 32'h4180, 0);
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("req_next", 32'h4184, 0);
    drive(1, 0, 0, 0, 1, 32'h3040);
    step(); chk("eret", 32'h3044, 0);
    drive(0, 0, 0, 1, 1, 32'h3040);
    step(); chk("req_eret", 32'h4180, 0);
    drive(0, 1, 32'hfffffffc, 0, 0, 0);
    step(); chk("top", 32'hfffffffc, 0);
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("wrap", 32'h00000000, 0);
    drive(0, 1, 32'h3102, 0, 0, 0);
    step(); chk("misal", 32'h3102, 0);
    check("misal_flag", 32'(bus.pc_misaligned), 1);
    drive(1, 1, 32'h3500, 0, 0, 0);
    step(); chk("pend4", 32'h3102, 1);
    reset = 1'b1;
    step(); chk("rst_pend", 32'h3000, 0);
    check("rst_mis", 32'(bus.pc_misaligned), 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("rst_after", 32'h3004, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
